rv_data_mem: RTL and testbench

RV_DATA_MEM -- requirements
Module: rv_data_mem

---
 rtl/rv_data_mem.sv | 182 ++++++++++++++++++
 tb/tb_rv_data_mem.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_data_mem.sv
// Byte-addressable 32-bit data memory for an RV32 core.
// One request in flight at a time: IDLE accepts, WAIT models extra read
// latency, RESP issues a single-cycle response strobe.
module rv_data_mem #(
    parameter int ADDR_WIDTH   = 7,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Address bits above the byte span must all be zero for a legal request.
    localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);
    // WAIT lasts WAIT_INIT+1 cycles, i.e. READ_LATENCY-1.
    localparam logic [1:0] WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       load_q, load_d;
    logic [1:0] size_q, size_d;
    logic [1:0] lane_q, lane_d;
    logic       uns_q, uns_d;

    logic                  accept;
    logic                  req_err;
    logic                  mem_we;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [3:0]            byte_en;
    logic [31:0]           wr_word;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           ext_data;

    // Request decode: word index, lane, legality, lane enables and replicated store data
    always_comb begin
        word_idx = req_addr[ADDR_WIDTH+1:2];
        lane     = req_addr[1:0];
        req_err  = (req_size == 2'b11)
                || ((req_size == 2'b01) && req_addr[0])
                || ((req_size == 2'b10) && (lane != 2'b00))
                || ((req_addr & HI_MASK) != 32'd0);
        accept   = req_valid && req_ready;
        mem_we   = accept && req_we && !req_err;
        rd_en    = accept && !req_we && !req_err;
        case (req_size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = req_wdata;
            end
        endcase
    end

    // One narrow RAM per byte lane so each lane has its own write enable.
    // Contents are deliberately not reset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];
        logic [7:0] rd_lane_q;

        // Lane write on store acceptance; registered snapshot on load acceptance
        always_ff @(posedge clk) begin
            if (mem_we && byte_en[gi]) begin
                mem_lane[word_idx] <= wr_word[gi*8 +: 8];
            end
            if (rd_en) begin
                rd_lane_q <= mem_lane[word_idx];
            end
        end

        assign rd_word[gi*8 +: 8] = rd_lane_q;
    end

    // State register plus the request attributes carried to the response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            size_q  <= 2'd0;
            lane_q  <= 2'd0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            uns_q   <= uns_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
        size_d  = size_q;
        lane_d  = lane_q;
        uns_d   = uns_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d  = req_err;
                    load_d = !req_we && !req_err;
                    size_d = req_size;
                    lane_d = lane;
                    uns_d  = req_unsigned;
                    if (!req_we && !req_err && (READ_LATENCY > 1)) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load extraction: shift addressed lane(s) down, then sign/zero extend
    always_comb begin
        rd_shift = rd_word >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   ext_data = uns_q ? {24'd0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ext_data = uns_q ? {16'd0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ext_data = rd_word;
        endcase
    end

    // Outputs decoded from state; response fields forced to zero outside RESP
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !reset;
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && load_q) ? ext_data : 32'd0;
    end

endmodule

// File: tb/tb_rv_data_mem.sv
// Bench for rv_data_mem: one instance with READ_LATENCY=1 and one with
// READ_LATENCY=3, checked against a byte-array reference model.
module tb_rv_data_mem;

    localparam int AW   = 7;
    localparam int SPAN = 4 * (2 ** AW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset1, reset3, valid1, valid3;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        ready1, ready3, rv1, rv3, err1, err3;
    logic [31:0] rd1, rd3;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] model1 [SPAN];
    logic [7:0] model3 [SPAN];

    rv_data_mem #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req_valid(valid1), .req_ready(ready1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1)
    );

    rv_data_mem #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset3), .req_valid(valid3), .req_ready(ready3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    endtask

    function automatic logic f_ready(input int inst);
        return (inst == 1) ? ready1 : ready3;
    endfunction
    function automatic logic f_rv(input int inst);
        return (inst == 1) ? rv1 : rv3;
    endfunction
    function automatic logic f_err(input int inst);
        return (inst == 1) ? err1 : err3;
    endfunction
    function automatic logic [31:0] f_rd(input int inst);
        return (inst == 1) ? rd1 : rd3;
    endfunction

    task automatic set_valid(input int inst, input logic v);
        if (inst == 1) valid1 = v;
        else valid3 = v;
    endtask

    // Reference model: byte-addressed memory, rules applied directly
    task automatic model_xact(input int inst, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rdata, output logic exp_err);
        int nb;
        int idx;
        logic [31:0] v;
        nb = 1 << size;
        v  = 32'd0;
        exp_err = (size == 2'd3) || ((size == 2'd1) && addr[0]) ||
                  ((size == 2'd2) && (addr[1:0] != 2'd0)) || (addr >= 32'(SPAN));
        exp_rdata = 32'd0;
        if (!exp_err) begin
            for (int b = 0; b < nb; b++) begin
                idx = int'(addr) + b;
                if (we) begin
                    if (inst == 1) model1[idx] = wdata[8*b +: 8];
                    else model3[idx] = wdata[8*b +: 8];
                end else begin
                    v = v | ({24'd0, (inst == 1) ? model1[idx] : model3[idx]} << (8 * b));
                end
            end
            if (!we) begin
                if (size == 2'd0 && !uns && v[7])  v = v | 32'hFFFFFF00;
                if (size == 2'd1 && !uns && v[15]) v = v | 32'hFFFF0000;
                exp_rdata = v;
            end
        end
    endtask

    task automatic wait_ready(input int inst);
        int waits;
        waits = 0;
        while (!f_ready(inst) && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check_val("ready_idle", {31'd0, f_ready(inst)}, 32'd1);
    endtask

    // Drive one request and collect its response; lat = negedges until rsp_valid
    task automatic xact(input int inst, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic got_err, output int lat);
        got_rdata = 32'd0;
        got_err   = 1'b0;
        wait_ready(inst);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        set_valid(inst, 1'b1);
        @(posedge clk);
        #1;
        set_valid(inst, 1'b0);
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            check_val("busy_ready", {31'd0, f_ready(inst)}, 32'd0);
            if (f_rv(inst)) begin
                got_rdata = f_rd(inst);
                got_err   = f_err(inst);
                break;
            end
            check_val("idle_rsp_zero", f_rd(inst) | {31'd0, f_err(inst)}, 32'd0);
        end
        if (lat > 20) check_val("rsp_timeout", {31'd0, f_rv(inst)}, 32'd1);
    endtask

    task automatic run(input int inst, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] got, output logic gerr);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        int          exp_lat;
        model_xact(inst, we, size, uns, addr, wdata, exp_rd, exp_err);
        xact(inst, we, size, uns, addr, wdata, got, gerr, lat);
        exp_lat = (!we && !exp_err) ? ((inst == 1) ? 1 : 3) : 1;
        check_val("rdata", got, exp_rd);
        check_val("err", {31'd0, gerr}, {31'd0, exp_err});
        check_val("latency", 32'(lat), 32'(exp_lat));
        $display("xact L%0d we=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 (inst == 1) ? 1 : 3, we, size, uns, addr, wdata, got, gerr, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, d_rd, a;
        logic        gerr, d_err, we, uns;
        logic [1:0]  sz;
        int          inst, accepts, rsps, last, s;

        reset1 = 1'b1; reset3 = 1'b1; valid1 = 1'b0; valid3 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

        // Reset: not ready, no response
        repeat (3) @(negedge clk);
        check_val("ready_in_reset1", {31'd0, ready1}, 32'd0);
        check_val("ready_in_reset3", {31'd0, ready3}, 32'd0);
        check_val("rsp_in_reset", {31'd0, rv1 | rv3}, 32'd0);
        reset1 = 1'b0; reset3 = 1'b0;
        #1;
        check_val("ready_after_reset1", {31'd0, ready1}, 32'd1);
        check_val("ready_after_reset3", {31'd0, ready3}, 32'd1);
        check_val("reset_rsp_valid", {30'd0, rv1, rv3}, 32'd0);
        check_val("reset_rsp_err", {30'd0, err1, err3}, 32'd0);
        check_val("reset_rsp_rdata", rd1 | rd3, 32'd0);

        // Preload every word of both memories
        for (int w = 0; w < SPAN / 4; w++) begin
            run(1, 1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, got, gerr);
            run(3, 1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, got, gerr);
        end

        // Store/load word with single-cycle latency
        run(1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h00500113, got, gerr);
        run(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got, gerr);
        check_val("lw_0x00", got, 32'h00500113);

        // Byte store into a word, then signed/unsigned/word loads
        run(1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344, got, gerr);
        run(1, 1'b1, 2'd0, 1'b0, 32'h5, 32'h00000080, got, gerr);
        run(1, 1'b0, 2'd0, 1'b0, 32'h5, 32'h0, got, gerr);
        check_val("lb_0x05", got, 32'hFFFFFF80);
        run(1, 1'b0, 2'd0, 1'b1, 32'h5, 32'h0, got, gerr);
        check_val("lbu_0x05", got, 32'h00000080);
        run(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, got, gerr);
        check_val("lw_0x04", got, 32'h11228044);

        // Error requests leave memory unchanged
        run(1, 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, got, gerr);
        check_val("err_lw_0x02", {31'd0, gerr}, 32'd1);
        run(1, 1'b0, 2'd1, 1'b0, 32'h3, 32'h0, got, gerr);
        check_val("err_lh_0x03", {31'd0, gerr}, 32'd1);
        run(1, 1'b1, 2'd3, 1'b0, 32'h4, 32'hFFFFFFFF, got, gerr);
        check_val("err_size3", {31'd0, gerr}, 32'd1);
        run(1, 1'b1, 2'd2, 1'b0, 32'h200, 32'hBAD0BAD0, got, gerr);
        check_val("err_addr_0x200", {31'd0, gerr}, 32'd1);
        check_val("err_rdata_zero", got, 32'd0);
        run(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got, gerr);
        check_val("unchanged_0x00", got, 32'h00500113);
        run(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, got, gerr);
        check_val("unchanged_0x04", got, 32'h11228044);

        // Three-cycle latency load, then IDLE re-entry
        run(3, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, got, gerr);
        run(3, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, got, gerr);
        check_val("lh_L3", got, 32'hFFFFBEEF);
        @(negedge clk);
        check_val("ready_reentry", {31'd0, ready3}, 32'd1);

        // Reset one cycle after a load is accepted: response discarded
        wait_ready(3);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        valid3 = 1'b1;
        @(posedge clk);
        #1;
        valid3 = 1'b0;
        @(negedge clk);
        reset3 = 1'b1;
        valid3 = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        #1;
        check_val("ready_during_reset", {31'd0, ready3}, 32'd0);
        @(negedge clk);
        check_val("rsp_during_reset", {31'd0, rv3}, 32'd0);
        reset3 = 1'b0; valid3 = 1'b0;
        #1;
        check_val("ready_post_reset", {31'd0, ready3}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("no_orphan_rsp", {31'd0, rv3}, 32'd0);
        end
        run(3, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got, gerr);

        // Back-to-back stores with req_valid held high
        wait_ready(1);
        accepts = 0; rsps = 0; last = -1;
        valid1 = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (rv1) rsps++;
            if (ready1) begin
                if (last >= 0) check_val("b2b_gap", 32'(c - last), 32'd2);
                last = c;
                accepts++;
                req_addr  = 32'h100 + 32'(4 * accepts);
                req_wdata = $urandom;
                model_xact(1, 1'b1, 2'd2, 1'b0, req_addr, req_wdata, d_rd, d_err);
            end
            @(negedge clk);
        end
        valid1 = 1'b0;
        check_val("b2b_accepts", 32'(accepts), 32'd8);
        check_val("b2b_rsps", 32'(rsps), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            run(1, 1'b0, 2'd2, 1'b0, 32'h100 + 32'(4 * k), 32'h0, got, gerr);
        end

        // Randomized mix on both instances
        for (int i = 0; i < 160; i++) begin
            inst = (i % 2 == 1) ? 3 : 1;
            s    = int'($urandom_range(0, 10));
            sz   = (s == 10) ? 2'd3 : 2'(s % 3);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, SPAN - 1));
            if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            run(inst, we, sz, uns, a, $urandom, got, gerr);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
